// File: rtl/wb_stage_if.sv
// Writeback stage bundle: upstream instruction handshake, load response and register-file write port.
// WB_FWD_EN adds the forwarding/hazard outputs.
interface wb_stage_if #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       in_opcode;
    logic [2:0]       in_funct3;
    logic [RADDR-1:0] in_rd;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_imm;
    logic [XLEN-1:0]  in_alu;
    logic             in_slt;
    logic             in_sltu;
    logic [2:0]       in_addr_lo;
    logic             mem_rvalid;
    logic [XLEN-1:0]  mem_rdata;
    logic             rf_we;
    logic [RADDR-1:0] rf_waddr;
    logic [XLEN-1:0]  rf_wdata;
    logic             busy;
`ifdef WB_FWD_EN
    logic             fwd_valid;
    logic [RADDR-1:0] fwd_rd;
    logic             fwd_pend;
`endif

    modport master (
        output in_valid, in_opcode, in_funct3, in_rd, in_pc, in_imm, in_alu,
               in_slt, in_sltu, in_addr_lo, mem_rvalid, mem_rdata,
        input  in_ready, rf_we, rf_waddr, rf_wdata, busy
`ifdef WB_FWD_EN
      , input  fwd_valid, fwd_rd, fwd_pend
`endif
    );

    modport slave (
        input  in_valid, in_opcode, in_funct3, in_rd, in_pc, in_imm, in_alu,
               in_slt, in_sltu, in_addr_lo, mem_rvalid, mem_rdata,
        output in_ready, rf_we, rf_waddr, rf_wdata, busy
`ifdef WB_FWD_EN
      , output fwd_valid, fwd_rd, fwd_pend
`endif
    );
endinterface

// File: rtl/wb_stage.sv
// Registered RV32I/RV64I writeback: selects/aligns the rd value, write port is flopped one cycle after accept
// (loads: one cycle after the response); stalls upstream only while a load waits. WB_FWD_EN adds forwarding outputs.
module wb_stage #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input logic   clk,
    input logic   rst,
    wb_stage_if.slave bus
);
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_32    = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [RADDR-1:0] pend_rd;
    logic [2:0]       pend_f3;
    logic [2:0]       pend_lo;
    logic             sel_we;
    logic [XLEN-1:0]  sel_val;
    logic [2:0]       lane;
    logic [7:0]       ld_b;
    logic [15:0]      ld_h;
    logic [31:0]      ld_w;
    logic [XLEN-1:0]  ld_val;
    logic             accept;
    logic             is_load;

    assign accept  = (state == S_IDLE) && bus.in_valid;
    assign is_load = (bus.in_opcode == OPC_LOAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.in_valid && is_load) state_nxt = S_WAIT;
            S_WAIT:  if (bus.mem_rvalid)          state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = (state == S_IDLE);
        bus.busy     = (state == S_WAIT);
    end

    // Non-load value select; loads are handled by the WAIT path.
    always_comb begin
        sel_we  = 1'b0;
        sel_val = '0;
        case (bus.in_opcode)
            OPC_JAL, OPC_JALR: begin
                sel_we  = 1'b1;
                sel_val = bus.in_pc + XLEN'(4);
            end
            OPC_LUI: begin
                sel_we  = 1'b1;
                sel_val = bus.in_imm;
            end
            OPC_AUIPC: begin
                sel_we  = 1'b1;
                sel_val = bus.in_pc + bus.in_imm;
            end
            OPC_OP, OPC_OP_IMM: begin
                sel_we = 1'b1;
                case (bus.in_funct3)
                    3'b010:  sel_val = XLEN'(bus.in_slt);
                    3'b011:  sel_val = XLEN'(bus.in_sltu);
                    default: sel_val = bus.in_alu;
                endcase
            end
            OPC_OP_32, OPC_OP_IMM32: begin
                if (XLEN == 64) begin
                    sel_we  = 1'b1;
                    sel_val = bus.in_alu;
                end
            end
            default: ;
        endcase
    end

    // Lane offsets: on RV32 addr_lo[2] is dropped, so the word lane is always 0.
    always_comb begin
        lane   = (XLEN == 64) ? pend_lo : {1'b0, pend_lo[1:0]};
        ld_b   = 8'(bus.mem_rdata >> {lane, 3'b000});
        ld_h   = 16'(bus.mem_rdata >> {lane[2:1], 4'b0000});
        ld_w   = 32'(bus.mem_rdata >> {lane[2], 5'b00000});
        ld_val = bus.mem_rdata;
        case (pend_f3)
            3'b000: ld_val = XLEN'($signed(ld_b));
            3'b100: ld_val = XLEN'(ld_b);
            3'b001: ld_val = XLEN'($signed(ld_h));
            3'b101: ld_val = XLEN'(ld_h);
            3'b010: if (XLEN == 64) ld_val = XLEN'($signed(ld_w));
            3'b110: if (XLEN == 64) ld_val = XLEN'(ld_w);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_rd      <= '0;
            pend_f3      <= '0;
            pend_lo      <= '0;
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
        end else begin
            bus.rf_we <= 1'b0;
            if (accept) begin
                if (is_load) begin
                    pend_rd <= bus.in_rd;
                    pend_f3 <= bus.in_funct3;
                    pend_lo <= bus.in_addr_lo;
                end else if (sel_we && (bus.in_rd != '0)) begin
                    bus.rf_we    <= 1'b1;
                    bus.rf_waddr <= bus.in_rd;
                    bus.rf_wdata <= sel_val;
                end
            end else if ((state == S_WAIT) && bus.mem_rvalid && (pend_rd != '0)) begin
                bus.rf_we    <= 1'b1;
                bus.rf_waddr <= pend_rd;
                bus.rf_wdata <= ld_val;
            end
        end
    end

`ifdef WB_FWD_EN
    assign bus.fwd_valid = bus.rf_we;
    assign bus.fwd_rd    = (state == S_WAIT) ? pend_rd : bus.rf_waddr;
    assign bus.fwd_pend  = (state == S_WAIT) && (pend_rd != '0);
`endif
endmodule
